// File: rtl/branch_pc_sequencer_if.sv
// rtl/branch_pc_sequencer_if.sv - core-side bus of the PC sequencer (control inputs, resolved redirects, PC/flush outputs)
// Ports (master = core/hazard side, slave = sequencer):
//   stall, halt_req, resume           pipeline control into the sequencer
//   br_valid, br_ne, eq, br_pc4,      BEQ/BNE resolution from execute
//   br_imm
//   j_valid, j_target                 J resolution
//   jr_valid, jr_addr                 JR resolution
//   pc, pc_plus4, flush, taken,       sequencer outputs
//   halted
interface branch_pc_sequencer_if;
    logic        stall;
    logic        halt_req;
    logic        resume;
    logic        br_valid;
    logic        br_ne;
    logic        eq;
    logic [31:0] br_pc4;
    logic [15:0] br_imm;
    logic        j_valid;
    logic [25:0] j_target;
    logic        jr_valid;
    logic [31:0] jr_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        taken;
    logic        halted;

    modport master (
        output stall, halt_req, resume,
        output br_valid, br_ne, eq, br_pc4, br_imm,
        output j_valid, j_target,
        output jr_valid, jr_addr,
        input  pc, pc_plus4, flush, taken, halted
    );

    modport slave (
        input  stall, halt_req, resume,
        input  br_valid, br_ne, eq, br_pc4, br_imm,
        input  j_valid, j_target,
        input  jr_valid, jr_addr,
        output pc, pc_plus4, flush, taken, halted
    );
endinterface

// File: rtl/branch_pc_sequencer.sv
// rtl/branch_pc_sequencer.sv - PC register, next-PC selection, branch/jump redirect with multi-cycle flush, stall and halt
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    branch_pc_sequencer_if.slave (controls, redirect sources, pc/pc_plus4/flush/taken/halted)
// Parameters:
//   RESET_PC      PC loaded on reset
//   FLUSH_CYCLES  cycles flush stays high after a redirect (1..7)
module branch_pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_pc_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [31:0] pc_q;
    logic [2:0]  cnt;
    logic        flush_q;
    logic        taken_q;
    logic        halted_q;

    logic        cond;
    logic        redirect;
    logic [31:0] br_target;
    logic [31:0] j_target_full;
    logic [31:0] target;

    // Redirect resolution; priority JR > J > branch. J takes its region
    // bits from the delay-slot PC (br_pc4), as in MIPS.
    always_comb begin
        cond          = bus.eq ^ bus.br_ne;
        br_target     = bus.br_pc4 + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};
        j_target_full = {bus.br_pc4[31:28], bus.j_target, 2'b00};
        redirect      = bus.jr_valid | bus.j_valid | (bus.br_valid & cond);
        if (bus.jr_valid) begin
            target = bus.jr_addr;
        end else if (bus.j_valid) begin
            target = j_target_full;
        end else begin
            target = br_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc_q     <= RESET_PC;
            cnt      <= 3'd0;
            flush_q  <= 1'b0;
            taken_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            taken_q <= 1'b0;
            case (state)
                RUN: begin
                    // A redirect beats both stall and halt_req so a resolved
                    // control transfer is never dropped.
                    if (redirect) begin
                        pc_q    <= target;
                        taken_q <= 1'b1;
                        flush_q <= 1'b1;
                        cnt     <= CNT_INIT;
                        if (FLUSH_CYCLES == 1) begin
                            state <= RUN;
                        end else begin
                            state <= FLUSH;
                        end
                    end else begin
                        flush_q <= 1'b0;
                        if (bus.halt_req) begin
                            state    <= HALTED;
                            halted_q <= 1'b1;
                        end else if (!bus.stall) begin
                            pc_q <= pc_q + 32'd4;
                        end
                    end
                end
                FLUSH: begin
                    // Redirect valids and halt_req are ignored here; they
                    // belong to wrong-path instructions or wait for RUN.
                    if (!bus.stall) begin
                        pc_q <= pc_q + 32'd4;
                    end
                    if (cnt == 3'd0) begin
                        flush_q <= 1'b0;
                        state   <= RUN;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                HALTED: begin
                    if (bus.resume) begin
                        halted_q <= 1'b0;
                        state    <= RUN;
                    end
                end
                default: begin
                    state    <= RUN;
                    flush_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_q + 32'd4;
    assign bus.flush    = flush_q;
    assign bus.taken    = taken_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// tb/tb_branch_pc_sequencer.sv - self-checking bench for branch_pc_sequencer
module tb_branch_pc_sequencer;

    localparam int FC = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    branch_pc_sequencer_if bus ();

    branch_pc_sequencer #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_pc;
    int          m_flush_left;
    bit          m_halted;
    bit          m_taken;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall    = 1'b0;
        bus.halt_req = 1'b0;
        bus.resume   = 1'b0;
        bus.br_valid = 1'b0;
        bus.br_ne    = 1'b0;
        bus.eq       = 1'b0;
        bus.br_pc4   = 32'h0;
        bus.br_imm   = 16'h0;
        bus.j_valid  = 1'b0;
        bus.j_target = 26'h0;
        bus.jr_valid = 1'b0;
        bus.jr_addr  = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One clock of the sequencer described at the level of its rules.
    task automatic model_step();
        bit          decide;
        bit          redir;
        logic [31:0] tgt;
        decide = !m_halted && (m_flush_left == 0 || FC == 1);
        redir  = 0;
        tgt    = 32'h0;
        if (bus.jr_valid) begin
            redir = 1; tgt = bus.jr_addr;
        end else if (bus.j_valid) begin
            redir = 1; tgt = (bus.br_pc4 & 32'hF000_0000) | (32'(bus.j_target) * 4);
        end else if (bus.br_valid && (bus.eq != bus.br_ne)) begin
            redir = 1; tgt = bus.br_pc4 + 32'(int'($signed(bus.br_imm)) * 4);
        end
        m_taken = 0;
        if (m_halted) begin
            if (bus.resume) m_halted = 0;
        end else if (!decide) begin
            m_flush_left--;
            if (!bus.stall) m_pc += 4;
        end else if (redir) begin
            m_pc         = tgt;
            m_taken      = 1;
            m_flush_left = FC;
        end else begin
            m_flush_left = 0;
            if (bus.halt_req) m_halted = 1;
            else if (!bus.stall) m_pc += 4;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        checks += 4;
        if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
        if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
        if (bus.taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", bus.taken); end
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (bus.pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc, 32'(i * 4)); end
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.pc !== 32'h0) begin errors++; $display("FAIL async_reset_pc: got %h want 0", bus.pc); end
        rst_n = 1'b1;
    endtask

    task automatic test_beq();
        do_reset();
        bus.br_valid = 1; bus.br_ne = 0; bus.eq = 1; bus.br_pc4 = 32'h100; bus.br_imm = 16'hFFFE;
        tick();
        checks += 3;
        if (bus.pc !== 32'hF8) begin errors++; $display("FAIL beq_pc: got %h want f8", bus.pc); end
        if (bus.taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", bus.taken); end
        if (bus.flush !== 1'b1) begin errors++; $display("FAIL beq_flush1: got %b want 1", bus.flush); end
        clear_inputs();
        tick();
        checks += 3;
        if (bus.pc !== 32'hFC) begin errors++; $display("FAIL beq_pc2: got %h want fc", bus.pc); end
        if (bus.taken !== 1'b0) begin errors++; $display("FAIL beq_taken2: got %b want 0", bus.taken); end
        if (bus.flush !== 1'b1) begin errors++; $display("FAIL beq_flush2: got %b want 1", bus.flush); end
        tick();
        checks += 2;
        if (bus.pc !== 32'h100) begin errors++; $display("FAIL beq_pc3: got %h want 100", bus.pc); end
        if (bus.flush !== 1'b0) begin errors++; $display("FAIL beq_flush3: got %b want 0", bus.flush); end
        bus.br_valid = 1; bus.br_ne = 0; bus.eq = 0; bus.br_pc4 = 32'h100; bus.br_imm = 16'hFFFE;
        tick();
        checks += 3;
        if (bus.pc !== 32'h104) begin errors++; $display("FAIL beq_nt_pc: got %h want 104", bus.pc); end
        if (bus.flush !== 1'b0) begin errors++; $display("FAIL beq_nt_flush: got %b want 0", bus.flush); end
        if (bus.taken !== 1'b0) begin errors++; $display("FAIL beq_nt_taken: got %b want 0", bus.taken); end
        clear_inputs();
    endtask

    task automatic test_bne_jr_j();
        do_reset();
        bus.br_valid = 1; bus.br_ne = 1; bus.eq = 0; bus.br_pc4 = 32'h40; bus.br_imm = 16'h0003;
        tick();
        checks += 2;
        if (bus.pc !== 32'h4C) begin errors++; $display("FAIL bne_pc: got %h want 4c", bus.pc); end
        if (bus.taken !== 1'b1) begin errors++; $display("FAIL bne_taken: got %b want 1", bus.taken); end
        clear_inputs();
        tick();
        tick();
        bus.br_valid = 1; bus.br_ne = 0; bus.eq = 1; bus.br_pc4 = 32'h100; bus.br_imm = 16'hFFFE;
        bus.jr_valid = 1; bus.jr_addr = 32'h2000;
        tick();
        checks++;
        if (bus.pc !== 32'h2000) begin errors++; $display("FAIL jr_prio_pc: got %h want 2000", bus.pc); end
        clear_inputs();
        tick();
        tick();
        bus.j_valid = 1; bus.j_target = 26'h0000010; bus.br_pc4 = 32'h3000_0000;
        tick();
        checks += 2;
        if (bus.pc !== 32'h3000_0040) begin errors++; $display("FAIL j_pc: got %h want 30000040", bus.pc); end
        if (bus.taken !== 1'b1) begin errors++; $display("FAIL j_taken: got %b want 1", bus.taken); end
        clear_inputs();
    endtask

    task automatic test_stall_redirect();
        do_reset();
        bus.stall = 1;
        tick();
        checks++;
        if (bus.pc !== 32'h0) begin errors++; $display("FAIL stall_hold_pc: got %h want 0", bus.pc); end
        bus.br_valid = 1; bus.eq = 1; bus.br_ne = 0; bus.br_pc4 = 32'h500; bus.br_imm = 16'h0;
        tick();
        checks += 2;
        if (bus.pc !== 32'h500) begin errors++; $display("FAIL stall_redirect_pc: got %h want 500", bus.pc); end
        if (bus.taken !== 1'b1) begin errors++; $display("FAIL stall_redirect_taken: got %b want 1", bus.taken); end
        bus.stall = 0; bus.br_pc4 = 32'h900;
        tick();
        checks += 3;
        if (bus.pc !== 32'h504) begin errors++; $display("FAIL flush_ignore_pc: got %h want 504", bus.pc); end
        if (bus.taken !== 1'b0) begin errors++; $display("FAIL flush_ignore_taken: got %b want 0", bus.taken); end
        if (bus.flush !== 1'b1) begin errors++; $display("FAIL flush_ignore_flush: got %b want 1", bus.flush); end
        tick();
        checks += 2;
        if (bus.pc !== 32'h508) begin errors++; $display("FAIL flush_ignore_pc2: got %h want 508", bus.pc); end
        if (bus.flush !== 1'b0) begin errors++; $display("FAIL flush_ignore_flush2: got %b want 0", bus.flush); end
        clear_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        bus.jr_valid = 1; bus.jr_addr = 32'h18;
        tick();
        clear_inputs();
        tick();
        tick();
        checks++;
        if (bus.pc !== 32'h20) begin errors++; $display("FAIL halt_setup_pc: got %h want 20", bus.pc); end
        bus.halt_req = 1;
        tick();
        checks += 2;
        if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_enter: got %b want 1", bus.halted); end
        if (bus.pc !== 32'h20) begin errors++; $display("FAIL halt_enter_pc: got %h want 20", bus.pc); end
        bus.halt_req = 0;
        for (int i = 0; i < 5; i++) begin
            bus.stall = 1'($urandom_range(0, 1));
            tick();
            checks += 2;
            if (bus.pc !== 32'h20) begin errors++; $display("FAIL halt_hold_pc[%0d]: got %h want 20", i, bus.pc); end
            if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_hold[%0d]: got %b want 1", i, bus.halted); end
        end
        bus.stall = 0; bus.resume = 1;
        tick();
        checks += 2;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL resume_halted: got %b want 0", bus.halted); end
        if (bus.pc !== 32'h20) begin errors++; $display("FAIL resume_pc: got %h want 20", bus.pc); end
        bus.resume = 0;
        tick();
        checks++;
        if (bus.pc !== 32'h24) begin errors++; $display("FAIL resume_next_pc: got %h want 24", bus.pc); end
        bus.halt_req = 1;
        tick();
        bus.resume = 1;
        tick();
        checks += 2;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL resume_wins: got %b want 0", bus.halted); end
        if (bus.pc !== 32'h24) begin errors++; $display("FAIL resume_wins_pc: got %h want 24", bus.pc); end
        clear_inputs();
        // halt_req during FLUSH waits for RUN
        bus.jr_valid = 1; bus.jr_addr = 32'h80;
        tick();
        clear_inputs();
        bus.halt_req = 1;
        tick();
        tick();
        checks += 2;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_deferred: got %b want 0", bus.halted); end
        if (bus.pc !== 32'h88) begin errors++; $display("FAIL halt_deferred_pc: got %h want 88", bus.pc); end
        tick();
        checks += 2;
        if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_after_flush: got %b want 1", bus.halted); end
        if (bus.pc !== 32'h88) begin errors++; $display("FAIL halt_after_flush_pc: got %h want 88", bus.pc); end
        clear_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        bus.jr_valid = 1; bus.jr_addr = 32'hFFFF_FFF4;
        tick();
        clear_inputs();
        tick();
        tick();
        checks++;
        if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup_pc: got %h want fffffffc", bus.pc); end
        tick();
        checks++;
        if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", bus.pc); end
        bus.br_valid = 1; bus.eq = 1; bus.br_ne = 0; bus.br_pc4 = 32'hFFFF_FFF0; bus.br_imm = 16'h0008;
        tick();
        checks++;
        if (bus.pc !== 32'h10) begin errors++; $display("FAIL wrap_target: got %h want 10", bus.pc); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.jr_valid = 1; bus.jr_addr = 32'h400;
        tick();
        clear_inputs();
        #3;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (bus.flush !== 1'b0) begin errors++; $display("FAIL mid_flush_reset_flush: got %b want 0", bus.flush); end
        if (bus.pc !== 32'h0) begin errors++; $display("FAIL mid_flush_reset_pc: got %h want 0", bus.pc); end
        rst_n = 1'b1;
        bus.halt_req = 1;
        tick();
        bus.halt_req = 0;
        #3;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL mid_halt_reset_halted: got %b want 0", bus.halted); end
        if (bus.pc !== 32'h0) begin errors++; $display("FAIL mid_halt_reset_pc: got %h want 0", bus.pc); end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        m_pc = 32'h0; m_flush_left = 0; m_halted = 0; m_taken = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.stall    = ($urandom_range(0, 3) == 0);
            bus.halt_req = ($urandom_range(0, 11) == 0);
            bus.resume   = ($urandom_range(0, 3) == 0);
            bus.br_valid = ($urandom_range(0, 4) == 0);
            bus.br_ne    = 1'($urandom);
            bus.eq       = 1'($urandom);
            bus.br_pc4   = $urandom;
            bus.br_imm   = 16'($urandom);
            bus.j_valid  = ($urandom_range(0, 9) == 0);
            bus.j_target = 26'($urandom);
            bus.jr_valid = ($urandom_range(0, 11) == 0);
            bus.jr_addr  = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            model_step();
            tick();
            checks += 5;
            if (bus.pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", c, bus.pc, m_pc); end
            if (bus.pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc_plus4[%0d]: got %h want %h", c, bus.pc_plus4, m_pc + 32'd4); end
            if (bus.flush !== (m_flush_left > 0)) begin errors++; $display("FAIL rnd_flush[%0d]: got %b want %b", c, bus.flush, m_flush_left > 0); end
            if (bus.taken !== m_taken) begin errors++; $display("FAIL rnd_taken[%0d]: got %b want %b", c, bus.taken, m_taken); end
            if (bus.halted !== m_halted) begin errors++; $display("FAIL rnd_halted[%0d]: got %b want %b", c, bus.halted, m_halted); end
        end
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_beq();
        test_bne_jr_j();
        test_stall_redirect();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
